// File: rtl/button_press_classifier_if.sv
// Event bundle between the button classifier and its consumer.
// master drives the press events; slave supplies the debounced level.
interface button_press_classifier_if;
   logic btn;
   logic short_press;
   logic long_press;
   logic double_press;
   logic repeat_pulse;
   logic busy;

   modport master (
      input  btn,
      output short_press,
      output long_press,
      output double_press,
      output repeat_pulse,
      output busy
   );

   modport slave (
      output btn,
      input  short_press,
      input  long_press,
      input  double_press,
      input  repeat_pulse,
      input  busy
   );
endinterface

// File: rtl/button_press_classifier.sv
// Short / long / double press classifier for a debounced button level.
// Define BTN_CLASS_REPEAT_EN for auto-repeat pulses during a long hold.
module button_press_classifier #(
   parameter int LONG_CYCLES   = 1000000,
   parameter int GAP_CYCLES    = 250000,
   parameter int REPEAT_CYCLES = 200000,
   parameter int CNT_W         = 21
) (
   input  logic                      clk,
   input  logic                      rst_n,
   button_press_classifier_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS1,
      S_WAIT,
      S_PRESS2,
      S_LONG
   } state_t;

   // The rise sample is the first high sample, so the L-th one is seen at cnt == L-2.
   localparam logic [CNT_W-1:0] LP_LONG_LAST = CNT_W'(LONG_CYCLES - 2);
   localparam logic [CNT_W-1:0] LP_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef BTN_CLASS_REPEAT_EN
   localparam logic [CNT_W-1:0] LP_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

   // Block name shows up in elaboration when the counter is too narrow.
   if (((64'd1 << CNT_W) <= 64'(LONG_CYCLES)) ||
       ((64'd1 << CNT_W) <= 64'(GAP_CYCLES)) ||
       ((64'd1 << CNT_W) <= 64'(REPEAT_CYCLES))) begin : g_cnt_w_too_small
   end

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_btn_q;
   logic             r_short;
   logic             r_long;
   logic             r_double;
   logic             r_busy;

   logic             w_rise;
   logic             w_fall;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_rise    = bus.btn & ~r_btn_q;
   assign w_fall    = ~bus.btn & r_btn_q;
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef BTN_CLASS_REPEAT_EN
   logic r_repeat;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_btn_q  <= 1'b1;
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_double <= 1'b0;
         r_busy   <= 1'b0;
`ifdef BTN_CLASS_REPEAT_EN
         r_repeat <= 1'b0;
`endif
      end else begin
         r_btn_q  <= bus.btn;
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_double <= 1'b0;
`ifdef BTN_CLASS_REPEAT_EN
         r_repeat <= 1'b0;
`endif
         unique case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state <= S_PRESS1;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            S_PRESS1: begin
               if (w_fall) begin
                  r_state <= S_WAIT;
                  r_cnt   <= '0;
               end else if (bus.btn) begin
                  if (r_cnt == LP_LONG_LAST) begin
                     r_long  <= 1'b1;
                     r_state <= S_LONG;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= w_cnt_inc;
                  end
               end
            end
            S_WAIT: begin
               // A rise on the timeout edge still counts as a double press.
               if (w_rise) begin
                  r_double <= 1'b1;
                  r_state  <= S_PRESS2;
                  r_cnt    <= '0;
               end else if (r_cnt == LP_GAP_LAST) begin
                  r_short  <= 1'b1;
                  r_state  <= S_IDLE;
                  r_cnt    <= '0;
                  r_busy   <= 1'b0;
               end else begin
                  r_cnt    <= w_cnt_inc;
               end
            end
            S_PRESS2: begin
               if (w_fall) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end
            S_LONG: begin
               if (w_fall) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
`ifdef BTN_CLASS_REPEAT_EN
               else if (bus.btn) begin
                  if (r_cnt == LP_REP_LAST) begin
                     r_repeat <= 1'b1;
                     r_cnt    <= '0;
                  end else begin
                     r_cnt    <= w_cnt_inc;
                  end
               end
`endif
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.short_press  = r_short;
   assign bus.long_press   = r_long;
   assign bus.double_press = r_double;
   assign bus.busy         = r_busy;
`ifdef BTN_CLASS_REPEAT_EN
   assign bus.repeat_pulse = r_repeat;
`else
   assign bus.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench for button_press_classifier with short test timings.
// Repeat expectations follow BTN_CLASS_REPEAT_EN.
module tb_button_press_classifier;

   localparam int L = 20;
   localparam int G = 8;
   localparam int R = 5;
   localparam int W = 6;

   localparam int EV_SHORT  = 0;
   localparam int EV_LONG   = 1;
   localparam int EV_DOUBLE = 2;
   localparam int EV_REPEAT = 3;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   button_press_classifier_if bus ();

   button_press_classifier #(
      .LONG_CYCLES   (L),
      .GAP_CYCLES    (G),
      .REPEAT_CYCLES (R),
      .CNT_W         (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic string kname(input int k);
      case (k)
         EV_SHORT:  return "short_press";
         EV_LONG:   return "long_press";
         EV_DOUBLE: return "double_press";
         default:   return "repeat_pulse";
      endcase
   endfunction

   task automatic push(input int k, input int c);
      exp_t e;
      e.kind = k;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   // Monitor: every pulse seen must match the head of the scoreboard.
   always @(negedge clk) begin : mon
      logic [3:0] v;
      exp_t       e;
      v = {bus.repeat_pulse, bus.double_press,
           bus.long_press, bus.short_press};
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
               n_cmp++;
               if (sb.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected %s at cycle %0d", kname(k), cyc);
               end else begin
                  e = sb.pop_front();
                  if (e.kind != k || e.cyc != cyc) begin
                     n_err++;
                     $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                              kname(k), cyc, kname(e.kind), e.cyc);
                  end
               end
            end
         end
      end
   end

   task automatic hold(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         bus.btn = v;
      end
   endtask

   // n high samples; second marks the press that should give double_press.
   task automatic press(input int n, input bit second, output int f);
      int r;
      @(negedge clk);
      bus.btn = 1'b1;
      r = cyc + 1;
      if (second) begin
         push(EV_DOUBLE, r);
      end else if (n >= L) begin
         push(EV_LONG, r + L - 1);
`ifdef BTN_CLASS_REPEAT_EN
         for (int t = r + L - 1 + R; t <= r + n - 1; t += R)
            push(EV_REPEAT, t);
`endif
      end
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      bus.btn = 1'b0;
      f = cyc + 1;
   endtask

   function automatic int pulses();
      return int'({bus.repeat_pulse, bus.double_press,
                   bus.long_press, bus.short_press});
   endfunction

   initial begin
      int f;
      int f2;
      bus.btn = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_pulses", pulses(), 0);
      rst_n = 1'b1;

      // Held through reset release: never a press.
      hold(1'b1, 30);
      check("held_busy", int'(bus.busy), 0);
      hold(1'b0, 30);
      check("held_low_busy", int'(bus.busy), 0);
      check("held_sb_left", sb.size(), 0);

      // Short press.
      press(5, 1'b0, f);
      push(EV_SHORT, f + G);
      hold(1'b0, 3);
      check("short_wait_busy", int'(bus.busy), 1);
      hold(1'b0, 12);
      check("short_idle_busy", int'(bus.busy), 0);
      check("short_sb_left", sb.size(), 0);

      // Double press, gap of 4 low samples.
      press(5, 1'b0, f);
      hold(1'b0, 3);
      press(5, 1'b1, f2);
      hold(1'b0, 1);
      check("double_rel_busy", int'(bus.busy), 0);
      hold(1'b0, 12);
      check("double_sb_left", sb.size(), 0);

      // 19 samples is short.
      press(19, 1'b0, f);
      push(EV_SHORT, f + G);
      hold(1'b0, 12);
      check("p19_sb_left", sb.size(), 0);
      check("p19_busy", int'(bus.busy), 0);

      // 20 samples is long, nothing on release.
      press(20, 1'b0, f);
      hold(1'b0, 1);
      check("p20_rel_busy", int'(bus.busy), 0);
      hold(1'b0, 12);
      check("p20_sb_left", sb.size(), 0);

      // 40 samples: long plus repeats when enabled.
      press(40, 1'b0, f);
      hold(1'b0, 12);
      check("p40_sb_left", sb.size(), 0);
      check("p40_busy", int'(bus.busy), 0);

      // Reset two cycles into the gap cancels the short press.
      press(5, 1'b0, f);
      hold(1'b0, 2);
      check("mid_wait_busy", int'(bus.busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", int'(bus.busy), 0);
      check("async_rst_pulses", pulses(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold(1'b0, 12);
      check("post_rst_sb_left", sb.size(), 0);
      check("post_rst_busy", int'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
